// File: rtl/mon_prod_param.sv
// Word-serial radix-2 Montgomery multiplier: P = A*B*2^(-N) mod M.
// Operands stream in from a single-port word RAM and the result streams back out.
module mon_prod_param #(
  parameter int BITLEN = 1024,
  parameter int DBITS  = 512,
  parameter int ABITS  = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [1:0]             op_code,
  input  logic [ABITS-1:0]       a_base,
  input  logic [ABITS-1:0]       b_base,
  input  logic [ABITS-1:0]       p_base,
  input  logic [BITLEN-1:0]      M,
  input  logic [$clog2(BITLEN):0] mp_count,
  output logic [ABITS-1:0]       rd_addr,
  input  logic [DBITS-1:0]       rd_data,
  output logic [ABITS-1:0]       wr_addr,
  output logic [DBITS-1:0]       wr_data,
  output logic                   wr_en,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  output logic [BITLEN-1:0]      P
);

  localparam int NW = BITLEN / DBITS;
  localparam int CW = $clog2(BITLEN) + 1;
  localparam int KW = $clog2(NW + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOADA, S_LOADB, S_CALC, S_FINAL, S_STORE, S_DONE
  } state_t;

  state_t              state_r;
  logic [1:0]          op_r;
  logic [ABITS-1:0]    b_base_r;
  logic [ABITS-1:0]    p_base_r;
  logic [KW-1:0]       wcnt_r;
  logic [CW-1:0]       bit_r;
  logic [BITLEN-1:0]   a_r;
  logic [BITLEN-1:0]   b_r;
  logic [BITLEN+1:0]   acc_r;

  logic [BITLEN+DBITS-1:0] a_cat_s;
  logic [BITLEN+DBITS-1:0] b_cat_s;
  logic [BITLEN-1:0]   a_ld_s;
  logic [BITLEN-1:0]   b_ld_s;
  logic [BITLEN+1:0]   addend_s;
  logic [BITLEN+1:0]   t_s;
  logic [BITLEN+1:0]   madd_s;
  logic [BITLEN+1:0]   acc_nx_s;
  logic                ge_s;
  logic [BITLEN-1:0]   diff_s;
  logic [BITLEN-1:0]   res_s;

  // Word shift-in paths, one Montgomery step and the final conditional subtract
  always_comb begin
    a_cat_s  = {rd_data, a_r};
    b_cat_s  = {rd_data, b_r};
    a_ld_s   = a_cat_s[BITLEN+DBITS-1:DBITS];
    b_ld_s   = b_cat_s[BITLEN+DBITS-1:DBITS];
    addend_s = a_r[0] ? {2'b00, b_r} : '0;
    t_s      = acc_r + addend_s;
    madd_s   = t_s[0] ? {2'b00, M} : '0;
    acc_nx_s = (t_s + madd_s) >> 1;
    // acc < 2M, so acc - M fits in BITLEN bits whenever it is non-negative
    ge_s     = (acc_r >= {2'b00, M});
    diff_s   = acc_r[BITLEN-1:0] - M;
    res_s    = ge_s ? diff_s : acc_r[BITLEN-1:0];
  end

  // Control FSM with registered RAM strobes and handshake outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= S_IDLE;
      op_r     <= 2'b00;
      b_base_r <= '0;
      p_base_r <= '0;
      wcnt_r   <= '0;
      bit_r    <= '0;
      a_r      <= '0;
      b_r      <= '0;
      acc_r    <= '0;
      rd_addr  <= '0;
      wr_addr  <= '0;
      wr_data  <= '0;
      wr_en    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      P        <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (start) begin
            if (!M[0] || (op_code == 2'd3)) begin
              done <= 1'b1;
              err  <= 1'b1;
            end else begin
              op_r     <= op_code;
              b_base_r <= b_base;
              p_base_r <= p_base;
              bit_r    <= (mp_count == '0) ? CW'(BITLEN) : mp_count;
              rd_addr  <= a_base;
              wcnt_r   <= '0;
              acc_r    <= '0;
              b_r      <= (op_code == 2'd2) ? BITLEN'(1) : '0;
              busy     <= 1'b1;
              state_r  <= S_LOADA;
            end
          end
        end
        S_LOADA: begin
          wcnt_r <= wcnt_r + KW'(1);
          if (wcnt_r != '0) begin
            a_r <= a_ld_s;
            if (op_r == 2'd0) begin
              b_r <= b_ld_s;
            end
          end
          if (wcnt_r < KW'(NW - 1)) begin
            rd_addr <= rd_addr + ABITS'(1);
          end
          if (wcnt_r == KW'(NW)) begin
            wcnt_r <= '0;
            if (op_r == 2'd1) begin
              rd_addr <= b_base_r;
              state_r <= S_LOADB;
            end else begin
              state_r <= S_CALC;
            end
          end
        end
        S_LOADB: begin
          wcnt_r <= wcnt_r + KW'(1);
          if (wcnt_r != '0) begin
            b_r <= b_ld_s;
          end
          if (wcnt_r < KW'(NW - 1)) begin
            rd_addr <= rd_addr + ABITS'(1);
          end
          if (wcnt_r == KW'(NW)) begin
            wcnt_r  <= '0;
            state_r <= S_CALC;
          end
        end
        S_CALC: begin
          acc_r <= acc_nx_s;
          a_r   <= a_r >> 1;
          bit_r <= bit_r - CW'(1);
          if (bit_r == CW'(1)) begin
            state_r <= S_FINAL;
          end
        end
        S_FINAL: begin
          P       <= res_s;
          a_r     <= res_s;
          wcnt_r  <= '0;
          state_r <= S_STORE;
        end
        S_STORE: begin
          if (wcnt_r == KW'(NW)) begin
            wr_en   <= 1'b0;
            done    <= 1'b1;
            busy    <= 1'b0;
            state_r <= S_DONE;
          end else begin
            wr_en   <= 1'b1;
            wr_data <= a_r[DBITS-1:0];
            a_r     <= a_r >> DBITS;
            wr_addr <= (wcnt_r == '0) ? p_base_r : wr_addr + ABITS'(1);
            wcnt_r  <= wcnt_r + KW'(1);
          end
        end
        S_DONE: begin
          state_r <= S_IDLE;
        end
        default: begin
          state_r <= S_IDLE;
        end
      endcase
    end
  end

endmodule
